// File: rtl/jtag_chain_bank.sv
// Bank of NUM_CH JTAG data-register scan chains for the AVR OCD / programmer TAP.
// Each chain has capture/shift/update stages, an update strobe with an ack handshake, and a sticky overrun flag.
module jtag_chain_bank #(
  parameter int                NUM_CH  = 3,
  parameter int                CH_W    = 19,
  parameter int                IR_LEN  = 4,
  parameter logic [IR_LEN-1:0] IR_BASE = 4'hD
) (
  input  logic                     trst_n,
  input  logic                     tck,
  input  logic                     tdi,
  input  logic [3:0]               tap_st,
  input  logic [IR_LEN-1:0]        ir,
  output logic                     tdo,
  output logic                     tdo_en,
  input  logic [NUM_CH*CH_W-1:0]   chain_i,
  output logic [NUM_CH*CH_W-1:0]   chain_o,
  output logic [NUM_CH-1:0]        chain_ud,
  input  logic [NUM_CH-1:0]        chain_ack,
  output logic [NUM_CH-1:0]        chain_ovr
);

  typedef enum logic [3:0] {
    ST_SHIFT_DR   = 4'h2,
    ST_UPDATE_DR  = 4'h5,
    ST_CAPTURE_DR = 4'h6,
    ST_TLR        = 4'hF
  } tap_state_e;

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] sh_lsb;
  logic              any_sel;
  logic              shift_bit;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [IR_LEN-1:0] CH_IR = IR_LEN'(int'(IR_BASE) + k);

    logic [CH_W:0]   sh;
    logic [CH_W-1:0] upd;
    logic            pending;
    logic            ovr;
    logic            ud;
    logic            upd_ev;
    logic            ovr_set;
    logic            capture;

    assign sel[k]   = (ir == CH_IR);
    assign upd_ev   = sel[k] && (tap_st == ST_UPDATE_DR);
    assign capture  = sel[k] && (tap_st == ST_CAPTURE_DR);
    // A second update before the consumer acked loses data; an ack on the same edge still counts.
    assign ovr_set  = upd_ev && pending && !chain_ack[k];

    always_ff @(posedge tck or negedge trst_n) begin
      if (!trst_n) begin
        sh      <= '0;
        pending <= 1'b0;
        ovr     <= 1'b0;
        ud      <= 1'b0;
      end else if (tap_st == ST_TLR) begin
        sh      <= '0;
        pending <= 1'b0;
        ovr     <= 1'b0;
        ud      <= 1'b0;
      end else begin
        ud <= upd_ev;

        if (upd_ev)
          pending <= 1'b1;
        else if (chain_ack[k])
          pending <= 1'b0;

        if (ovr_set)
          ovr <= 1'b1;
        else if (capture)
          ovr <= 1'b0;

        if (capture)
          sh <= {chain_i[k*CH_W +: CH_W], ovr};
        else if (sel[k] && (tap_st == ST_SHIFT_DR))
          sh <= {tdi, sh[CH_W:1]};
      end
    end

    // Update register loads mid-UpdateDR so chain_o is stable before the strobe rises.
    always_ff @(negedge tck or negedge trst_n) begin
      if (!trst_n)
        upd <= '0;
      else if (upd_ev)
        upd <= sh[CH_W:1];
    end

    assign chain_o[k*CH_W +: CH_W] = upd;
    assign chain_ud[k]             = ud;
    assign chain_ovr[k]            = ovr;
    assign sh_lsb[k]               = sh[0];
  end

  assign any_sel   = |sel;
  assign shift_bit = |(sh_lsb & sel);

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end else if ((tap_st == ST_SHIFT_DR) && any_sel) begin
      tdo    <= shift_bit;
      tdo_en <= 1'b1;
    end else begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
    end
  end

endmodule
